// File: rtl/dpdm_rx.sv
// Host-side USB DP/DM line receiver: SYNC check, symbol forwarding,
// EOP detection, error and timeout reporting.
module dpdm_rx #(
    parameter int TIMEOUT  = 16,
    parameter int MAX_BITS = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] host_in,
    input  logic       rx_start,
    output logic       s_out,
    output logic       s_valid,
    output logic       rx_done,
    output logic       rx_err,
    output logic       rx_timeout,
    output logic       busy
);

    localparam int BW = $clog2(MAX_BITS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    // Bit i is the expected level of SYNC symbol i (1=J, 0=K): K J K J K J K K
    localparam logic [7:0] SYNC_PAT = 8'b0010_1010;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        SYNC,
        DATA,
        EOP1,
        EOP2
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]      sync_idx_q, sync_idx_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            s_out_q, s_out_d;
    logic            s_valid_q, s_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            to_q, to_d;

    logic is_j, is_k, is_se0, sync_ok;

    assign is_j    = (host_in == 2'b10);
    assign is_k    = (host_in == 2'b01);
    assign is_se0  = (host_in == 2'b00);
    assign sync_ok = (is_j || is_k) && (is_j == SYNC_PAT[sync_idx_q]);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        sync_idx_d = sync_idx_q;
        bit_cnt_d  = bit_cnt_q;
        s_out_d    = 1'b0;
        s_valid_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        to_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_start) begin
                    state_d    = WAIT_SYNC;
                    wait_cnt_d = '0;
                end
            end
            WAIT_SYNC: begin
                if (is_j) begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                    if (wait_cnt_q + WW'(1) == WW'(TIMEOUT)) begin
                        state_d = IDLE;
                        to_d    = 1'b1;
                    end
                end else if (is_k) begin
                    state_d    = SYNC;
                    sync_idx_d = 3'd1;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            SYNC: begin
                if (!sync_ok) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (sync_idx_q == 3'd7) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    sync_idx_d = sync_idx_q + 3'd1;
                end
            end
            DATA: begin
                if (is_j || is_k) begin
                    if (bit_cnt_q == BW'(MAX_BITS)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        s_valid_d = 1'b1;
                        s_out_d   = is_j;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (is_se0) begin
                    state_d = EOP1;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            EOP1: begin
                if (is_se0) begin
                    state_d = EOP2;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            EOP2: begin
                state_d = IDLE;
                if (is_j) done_d = 1'b1;
                else      err_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            sync_idx_q <= '0;
            bit_cnt_q  <= '0;
            s_out_q    <= 1'b0;
            s_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sync_idx_q <= sync_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            s_out_q    <= s_out_d;
            s_valid_q  <= s_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_q       <= to_d;
        end
    end

    assign s_out      = s_out_q;
    assign s_valid    = s_valid_q;
    assign rx_done    = done_q;
    assign rx_err     = err_q;
    assign rx_timeout = to_q;
    assign busy       = (state_q != IDLE);

endmodule
